// File: rtl/ex_wb_dest_pipe.sv
// ex_wb_dest_pipe
//   Carries the EX-stage destination register number and write/load control
//   through the MEM and WB pipeline slots. It also produces operand-forwarding
//   selects for the EX-stage sources and the load-use hazard indication for
//   the ID stage.
//
// Ports
//   clk            rising-edge system clock
//   reset          synchronous, active-high; clears both slots; overrides stall/flush
//   dest_ex        EX destination register (rt/rd select result)
//   regwrite_ex    EX instruction writes the register file
//   memread_ex     EX instruction is a load
//   rs_ex, rt_ex   EX source registers (forwarding compare)
//   rs_id, rt_id   ID source registers (load-use compare)
//   stall          hold both slots this cycle; EX inputs are ignored
//   flush_ex       replace the EX instruction with a bubble entering MEM
//   dest_mem/_wb   registered destination numbers
//   regwrite_mem/_wb, memread_mem  registered per-slot control
//   forward_a/_b   00 regfile, 10 MEM slot, 01 WB slot
//   load_use_stall ID instruction depends on a load currently in EX
module ex_wb_dest_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dest_ex,
  input  logic       regwrite_ex,
  input  logic       memread_ex,
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       stall,
  input  logic       flush_ex,
  output logic [4:0] dest_mem,
  output logic [4:0] dest_wb,
  output logic       regwrite_mem,
  output logic       regwrite_wb,
  output logic       memread_mem,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       load_use_stall
);

  // Only the WB fields that are visible on the ports are stored; memread is
  // not needed beyond the MEM slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_mem     <= '0;
      regwrite_mem <= 1'b0;
      memread_mem  <= 1'b0;
      dest_wb      <= '0;
      regwrite_wb  <= 1'b0;
    end else if (!stall) begin
      dest_wb     <= dest_mem;
      regwrite_wb <= regwrite_mem;
      if (flush_ex) begin
        dest_mem     <= '0;
        regwrite_mem <= 1'b0;
        memread_mem  <= 1'b0;
      end else begin
        dest_mem     <= dest_ex;
        regwrite_mem <= regwrite_ex;
        memread_mem  <= memread_ex;
      end
    end
  end

  // Register 0 is hard-wired, so a slot targeting it never forwards.
  logic mem_writes;
  logic wb_writes;

  always_comb begin
    mem_writes = regwrite_mem && (dest_mem != '0);
    wb_writes  = regwrite_wb  && (dest_wb  != '0);

    forward_a = 2'b00;
    if (mem_writes && (dest_mem == rs_ex))     forward_a = 2'b10;
    else if (wb_writes && (dest_wb == rs_ex))  forward_a = 2'b01;

    forward_b = 2'b00;
    if (mem_writes && (dest_mem == rt_ex))     forward_b = 2'b10;
    else if (wb_writes && (dest_wb == rt_ex))  forward_b = 2'b01;

    load_use_stall = memread_ex && !flush_ex && (dest_ex != '0) &&
                     ((dest_ex == rs_id) || (dest_ex == rt_id));
  end

endmodule

// File: tb/tb_ex_wb_dest_pipe.sv
module tb_ex_wb_dest_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] dest_ex;
  logic       regwrite_ex;
  logic       memread_ex;
  logic [4:0] rs_ex, rt_ex, rs_id, rt_id;
  logic       stall;
  logic       flush_ex;
  logic [4:0] dest_mem, dest_wb;
  logic       regwrite_mem, regwrite_wb, memread_mem;
  logic [1:0] forward_a, forward_b;
  logic       load_use_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_wb_dest_pipe dut (
    .clk(clk), .reset(reset),
    .dest_ex(dest_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .stall(stall), .flush_ex(flush_ex),
    .dest_mem(dest_mem), .dest_wb(dest_wb),
    .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_mem(memread_mem),
    .forward_a(forward_a), .forward_b(forward_b), .load_use_stall(load_use_stall)
  );

  // Reference: a two-entry queue of in-flight instructions, [0]=MEM, [1]=WB.
  typedef struct {
    logic [4:0] d;
    logic       rw;
    logic       mr;
  } ent_t;

  ent_t pipe[$];
  ent_t bubble = '{d: 5'd0, rw: 1'b0, mr: 1'b0};

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (pipe[0].rw && pipe[0].d != 0 && pipe[0].d == src) return 2'b10;
    if (pipe[1].rw && pipe[1].d != 0 && pipe[1].d == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lus();
    if (flush_ex || !memread_ex || dest_ex == 0) return 1'b0;
    return (dest_ex == rs_id) || (dest_ex == rt_id);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge: the model consumes the inputs present at the edge.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (reset) begin
      pipe = '{bubble, bubble};
    end else if (!stall) begin
      e = flush_ex ? bubble : '{d: dest_ex, rw: regwrite_ex, mr: memread_ex};
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    #1;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".dest_mem"},     {3'b0, dest_mem},     {3'b0, pipe[0].d});
    chk({ctx, ".regwrite_mem"}, {7'b0, regwrite_mem}, {7'b0, pipe[0].rw});
    chk({ctx, ".memread_mem"},  {7'b0, memread_mem},  {7'b0, pipe[0].mr});
    chk({ctx, ".dest_wb"},      {3'b0, dest_wb},      {3'b0, pipe[1].d});
    chk({ctx, ".regwrite_wb"},  {7'b0, regwrite_wb},  {7'b0, pipe[1].rw});
    chk({ctx, ".forward_a"},    {6'b0, forward_a},    {6'b0, exp_fwd(rs_ex)});
    chk({ctx, ".forward_b"},    {6'b0, forward_b},    {6'b0, exp_fwd(rt_ex)});
    chk({ctx, ".load_use"},     {7'b0, load_use_stall}, {7'b0, exp_lus()});
  endtask

  task automatic set_ex(input logic [4:0] d, input logic rw, input logic mr);
    dest_ex = d; regwrite_ex = rw; memread_ex = mr;
  endtask

  initial begin
    pipe = '{bubble, bubble};
    reset = 1'b1; stall = 1'b0; flush_ex = 1'b0;
    set_ex(5'd0, 1'b0, 1'b0);
    rs_ex = 5'd1; rt_ex = 5'd2; rs_id = 5'd3; rt_id = 5'd4;

    // Reset state
    tick();
    chk("rst.dest_mem", {3'b0, dest_mem}, 8'd0);
    chk("rst.dest_wb", {3'b0, dest_wb}, 8'd0);
    chk("rst.fwd_a", {6'b0, forward_a}, 8'd0);
    check_all("rst");
    reset = 1'b0;

    // Latency: dest 8 reaches MEM after one edge, WB after two
    set_ex(5'd8, 1'b1, 1'b0);
    tick();
    chk("lat.dest_mem", {3'b0, dest_mem}, 8'd8);
    chk("lat.rw_mem", {7'b0, regwrite_mem}, 8'd1);
    chk("lat.dest_wb_early", {3'b0, dest_wb}, 8'd0);
    set_ex(5'd0, 1'b0, 1'b0);
    tick();
    chk("lat.dest_wb", {3'b0, dest_wb}, 8'd8);
    chk("lat.rw_wb", {7'b0, regwrite_wb}, 8'd1);
    check_all("lat");

    // Forwarding priority: both slots hold 3 and write -> MEM wins
    set_ex(5'd3, 1'b1, 1'b0);
    tick(); tick();
    rs_ex = 5'd3; rt_ex = 5'd0; #1;
    chk("fwd.mem_wins", {6'b0, forward_a}, 8'h02);
    check_all("fwd_both");
    // Only WB writing register 3
    set_ex(5'd3, 1'b0, 1'b0);
    tick();
    rt_ex = 5'd3; #1;
    chk("fwd.wb_only", {6'b0, forward_b}, 8'h01);
    check_all("fwd_wb");

    // Register 0 never forwards
    set_ex(5'd0, 1'b1, 1'b0);
    tick();
    rs_ex = 5'd0; #1;
    chk("fwd.r0", {6'b0, forward_a}, 8'h00);
    check_all("fwd_r0");

    // Load-use hazard and flush suppression
    set_ex(5'd7, 1'b1, 1'b1);
    rs_id = 5'd1; rt_id = 5'd7; #1;
    chk("lus.hit", {7'b0, load_use_stall}, 8'd1);
    flush_ex = 1'b1; #1;
    chk("lus.flushed", {7'b0, load_use_stall}, 8'd0);
    tick();
    chk("flush.memread_mem", {7'b0, memread_mem}, 8'd0);
    chk("flush.dest_mem", {3'b0, dest_mem}, 8'd0);
    check_all("flush");
    flush_ex = 1'b0;

    // Stall beats flush for two edges
    set_ex(5'd4, 1'b1, 1'b0); tick();
    set_ex(5'd9, 1'b1, 1'b0); tick();
    stall = 1'b1; flush_ex = 1'b1; set_ex(5'd5, 1'b1, 1'b1);
    tick(); tick();
    chk("stall.dest_mem", {3'b0, dest_mem}, 8'd9);
    chk("stall.dest_wb", {3'b0, dest_wb}, 8'd4);
    check_all("stall");

    // Reset overrides stall
    reset = 1'b1;
    tick();
    chk("rst_stall.dest_mem", {3'b0, dest_mem}, 8'd0);
    chk("rst_stall.dest_wb", {3'b0, dest_wb}, 8'd0);
    chk("rst_stall.rw_wb", {7'b0, regwrite_wb}, 8'd0);
    check_all("rst_stall");
    reset = 1'b0; stall = 1'b0; flush_ex = 1'b0;

    // Randomized traffic, small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush_ex = ($urandom_range(0, 6) == 0);
      set_ex(5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      rs_ex = 5'($urandom_range(0, 7));
      rt_ex = 5'($urandom_range(0, 7));
      rs_id = 5'($urandom_range(0, 7));
      rt_id = 5'($urandom_range(0, 7));
      #1;
      check_all("rnd_pre");
      tick();
      check_all("rnd_post");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
